// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the single-bus 32-bit CPU.
// Fetch/decode/execute microsteps with a memory ready handshake and a bus timeout.
module control_sequencer #(
    parameter int MEM_TIMEOUT = 8,
    parameter int TO_W        = 4,
    parameter int ALUOP_W     = 4,
    parameter int BR_LSB      = 23
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [31:0]        IR,
    input  logic               CON_FF,
    input  logic               MemReady,
    input  logic               Stop,
    output logic               Gra,
    output logic               Grb,
    output logic               Grc,
    output logic               Rin,
    output logic               Rout,
    output logic               BAout,
    output logic               Cout,
    output logic               PCout,
    output logic               PCin,
    output logic               IncPC,
    output logic               IRin,
    output logic               MARin,
    output logic               MDRin,
    output logic               MDRout,
    output logic               Yin,
    output logic               Zin,
    output logic               Zlowout,
    output logic               Zhighout,
    output logic               LOin,
    output logic               HIin,
    output logic               LOout,
    output logic               HIout,
    output logic               CONin,
    output logic               InPortout,
    output logic               OutPortin,
    output logic               Read,
    output logic               Write,
    output logic [ALUOP_W-1:0] AluOp,
    output logic               Run,
    output logic               IllegalOp,
    output logic               BusError
);

    typedef enum logic [3:0] {
        S_RESET, S_PAUSE, S_HALT, S_F0, S_F1, S_FW, S_F2,
        S_DEC, S_E3, S_E4, S_E5, S_E6, S_E7, S_EW
    } state_t;

    typedef enum logic [4:0] {
        C_LD, C_LDI, C_ST, C_RR, C_RI, C_MD, C_UN, C_BR, C_JR,
        C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HLT, C_ILL
    } cls_t;

    localparam logic [26:0] GRA = 27'd1 << 26, GRB = 27'd1 << 25;
    localparam logic [26:0] GRC = 27'd1 << 24, RIN = 27'd1 << 23;
    localparam logic [26:0] ROUT = 27'd1 << 22, BAOUT = 27'd1 << 21;
    localparam logic [26:0] COUT = 27'd1 << 20, PCOUT = 27'd1 << 19;
    localparam logic [26:0] PCIN = 27'd1 << 18, INCPC = 27'd1 << 17;
    localparam logic [26:0] IRIN = 27'd1 << 16, MARIN = 27'd1 << 15;
    localparam logic [26:0] MDRIN = 27'd1 << 14, MDROUT = 27'd1 << 13;
    localparam logic [26:0] YIN = 27'd1 << 12, ZIN = 27'd1 << 11;
    localparam logic [26:0] ZLOW = 27'd1 << 10, ZHIGH = 27'd1 << 9;
    localparam logic [26:0] LOIN = 27'd1 << 8, HIIN = 27'd1 << 7;
    localparam logic [26:0] LOOUT = 27'd1 << 6, HIOUT = 27'd1 << 5;
    localparam logic [26:0] CONIN = 27'd1 << 4, INPOUT = 27'd1 << 3;
    localparam logic [26:0] OUTPIN = 27'd1 << 2, READ = 27'd1 << 1;
    localparam logic [26:0] WRITE = 27'd1;

    localparam bit TO_EN = MEM_TIMEOUT > 0;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    function automatic cls_t cls_of(input logic [4:0] o);
        case (o) inside
            5'h00:          return C_LD;
            5'h01:          return C_LDI;
            5'h02:          return C_ST;
            [5'h03:5'h0A]:  return C_RR;
            [5'h0B:5'h0D]:  return C_RI;
            5'h0E, 5'h0F:   return C_MD;
            5'h10, 5'h11:   return C_UN;
            5'h12:          return C_BR;
            5'h13:          return C_JR;
            5'h14:          return C_JAL;
            5'h15:          return C_IN;
            5'h16:          return C_OUT;
            5'h17:          return C_MFHI;
            5'h18:          return C_MFLO;
            5'h19:          return C_NOP;
            5'h1A:          return C_HLT;
            default:        return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] o);
        case (o)
            5'h04:        return 4'd1;
            5'h05:        return 4'd4;
            5'h06:        return 4'd5;
            5'h07:        return 4'd6;
            5'h08:        return 4'd7;
            5'h09, 5'h0C: return 4'd2;
            5'h0A, 5'h0D: return 4'd3;
            5'h0E:        return 4'd8;
            5'h0F:        return 4'd9;
            5'h10:        return 4'd10;
            5'h11:        return 4'd11;
            default:      return 4'd0;
        endcase
    endfunction

    state_t          state, bnd;
    logic [4:0]      op;
    logic [TO_W-1:0] wcnt;
    cls_t            cls, dcls;
    logic            timeout;
    logic [26:0]     sb;
    logic [3:0]      alu;

    // The branch condition field is consumed by the external CON logic.
    logic [1:0] unused_br;
    logic       unused_ir;
    assign unused_br = IR[BR_LSB+1 -: 2];
    assign unused_ir = ^IR[26:0];

    assign cls     = cls_of(op);
    assign dcls    = cls_of(IR[31:27]);
    assign bnd     = Stop ? S_PAUSE : S_F0;
    assign timeout = TO_EN && (wcnt == TO_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= S_RESET;
            op        <= '0;
            wcnt      <= '0;
            IllegalOp <= 1'b0;
            BusError  <= 1'b0;
        end else begin
            unique case (state)
                S_RESET: state <= S_F0;
                S_PAUSE: if (!Stop) state <= S_F0;
                S_HALT:  state <= S_HALT;
                S_F0:    state <= S_F1;
                S_F1: begin
                    state <= S_FW;
                    wcnt  <= '0;
                end
                S_FW: begin
                    if (MemReady) state <= S_F2;
                    else if (timeout) begin
                        state    <= S_HALT;
                        BusError <= 1'b1;
                    end else wcnt <= wcnt + 1'b1;
                end
                S_F2: state <= S_DEC;
                S_DEC: begin
                    op <= IR[31:27];
                    case (dcls)
                        C_NOP:   state <= bnd;
                        C_HLT:   state <= S_HALT;
                        C_ILL: begin
                            state     <= S_HALT;
                            IllegalOp <= 1'b1;
                        end
                        default: state <= S_E3;
                    endcase
                end
                S_E3: state <= (cls inside {C_JR, C_IN, C_OUT, C_MFHI, C_MFLO})
                               ? bnd : S_E4;
                S_E4: state <= (cls inside {C_UN, C_JAL}) ? bnd : S_E5;
                S_E5: begin
                    if (cls == C_LD) begin
                        state <= S_EW;
                        wcnt  <= '0;
                    end else
                        state <= (cls inside {C_RR, C_RI, C_LDI}) ? bnd : S_E6;
                end
                S_E6: begin
                    if (cls == C_ST) begin
                        state <= S_EW;
                        wcnt  <= '0;
                    end else state <= bnd;
                end
                S_EW: begin
                    if (MemReady) state <= (cls == C_LD) ? S_E7 : bnd;
                    else if (timeout) begin
                        state    <= S_HALT;
                        BusError <= 1'b1;
                    end else wcnt <= wcnt + 1'b1;
                end
                S_E7:    state <= bnd;
                default: state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        sb  = '0;
        alu = '0;
        case (state)
            S_F0: sb = PCOUT | MARIN | INCPC | ZIN;
            S_F1: sb = ZLOW | PCIN;
            S_FW: sb = READ | MDRIN;
            S_F2: sb = MDROUT | IRIN;
            S_E3: case (cls)
                C_RR, C_RI, C_MD: sb = GRB | ROUT | YIN;
                C_UN: begin
                    sb  = GRB | ROUT | ZIN;
                    alu = alu_of(op);
                end
                C_LD, C_LDI, C_ST: sb = GRB | BAOUT | YIN;
                C_BR:   sb = GRA | ROUT | CONIN;
                C_JR:   sb = GRA | ROUT | PCIN;
                C_JAL:  sb = PCOUT | GRB | RIN;
                C_IN:   sb = GRA | RIN | INPOUT;
                C_OUT:  sb = GRA | ROUT | OUTPIN;
                C_MFHI: sb = GRA | RIN | HIOUT;
                C_MFLO: sb = GRA | RIN | LOOUT;
                default: sb = '0;
            endcase
            S_E4: case (cls)
                C_RR, C_MD: begin
                    sb  = GRC | ROUT | ZIN;
                    alu = alu_of(op);
                end
                C_RI: begin
                    sb  = COUT | ZIN;
                    alu = alu_of(op);
                end
                C_UN:  sb = ZLOW | GRA | RIN;
                C_LD, C_LDI, C_ST: sb = COUT | ZIN;
                C_BR:  sb = PCOUT | YIN;
                C_JAL: sb = GRA | ROUT | PCIN;
                default: sb = '0;
            endcase
            S_E5: case (cls)
                C_RR, C_RI, C_LDI: sb = ZLOW | GRA | RIN;
                C_MD:       sb = ZLOW | LOIN;
                C_LD, C_ST: sb = ZLOW | MARIN;
                C_BR:       sb = COUT | ZIN;
                default:    sb = '0;
            endcase
            S_E6: case (cls)
                C_MD:    sb = ZHIGH | HIIN;
                C_ST:    sb = GRA | ROUT | MDRIN;
                C_BR:    sb = ZLOW | (CON_FF ? PCIN : '0);
                default: sb = '0;
            endcase
            S_EW: sb = (cls == C_LD) ? (READ | MDRIN) : WRITE;
            S_E7: sb = MDROUT | GRA | RIN;
            default: sb = '0;
        endcase
    end

    assign {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC,
            IRin, MARin, MDRin, MDRout, Yin, Zin, Zlowout, Zhighout,
            LOin, HIin, LOout, HIout, CONin, InPortout, OutPortin,
            Read, Write} = sb;
    assign AluOp = ALUOP_W'(alu);
    assign Run   = !(state inside {S_RESET, S_PAUSE, S_HALT});

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction microstep tables
// expanded into an expected cycle trace, with random opcodes, waits and stops.
module tb_control_sequencer;
    logic Clock = 1'b0, Reset = 1'b1;
    logic [31:0] IR = '0;
    logic CON_FF = 1'b0, MemReady = 1'b0, Stop = 1'b0;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC;
    logic IRin, MARin, MDRin, MDRout, Yin, Zin, Zlowout, Zhighout;
    logic LOin, HIin, LOout, HIout, CONin, InPortout, OutPortin;
    logic Read, Write, Run, IllegalOp, BusError;
    logic [3:0] AluOp;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .CON_FF(CON_FF),
        .MemReady(MemReady), .Stop(Stop),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Cout(Cout), .PCout(PCout), .PCin(PCin),
        .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin), .LOout(LOout),
        .HIout(HIout), .CONin(CONin), .InPortout(InPortout),
        .OutPortin(OutPortin), .Read(Read), .Write(Write),
        .AluOp(AluOp), .Run(Run), .IllegalOp(IllegalOp),
        .BusError(BusError)
    );

    localparam logic [26:0] GRA = 27'd1 << 26, GRB = 27'd1 << 25;
    localparam logic [26:0] GRC = 27'd1 << 24, RIN = 27'd1 << 23;
    localparam logic [26:0] ROUT = 27'd1 << 22, BAOUT = 27'd1 << 21;
    localparam logic [26:0] COUT = 27'd1 << 20, PCOUT = 27'd1 << 19;
    localparam logic [26:0] PCIN = 27'd1 << 18, INCPC = 27'd1 << 17;
    localparam logic [26:0] IRIN = 27'd1 << 16, MARIN = 27'd1 << 15;
    localparam logic [26:0] MDRIN = 27'd1 << 14, MDROUT = 27'd1 << 13;
    localparam logic [26:0] YIN = 27'd1 << 12, ZIN = 27'd1 << 11;
    localparam logic [26:0] ZLOW = 27'd1 << 10, ZHIGH = 27'd1 << 9;
    localparam logic [26:0] LOIN = 27'd1 << 8, HIIN = 27'd1 << 7;
    localparam logic [26:0] LOOUT = 27'd1 << 6, HIOUT = 27'd1 << 5;
    localparam logic [26:0] CONIN = 27'd1 << 4, INPOUT = 27'd1 << 3;
    localparam logic [26:0] OUTPIN = 27'd1 << 2, READ = 27'd1 << 1;
    localparam logic [26:0] WRITE = 27'd1;

    typedef struct {
        logic [26:0] s;
        logic [3:0]  alu;
        logic        run, ill, bus, mr, con, stop;
        logic [31:0] ir;
    } step_t;

    step_t q[$];
    int vectors = 0, miscompares = 0;
    logic x_ill = 1'b0, x_bus = 1'b0;
    logic [31:0] cur_ir = '0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] o);
        case (o)
            5'h03, 5'h0B: return 4'd0;
            5'h04: return 4'd1;
            5'h09, 5'h0C: return 4'd2;
            5'h0A, 5'h0D: return 4'd3;
            5'h05: return 4'd4;
            5'h06: return 4'd5;
            5'h07: return 4'd6;
            5'h08: return 4'd7;
            5'h0E: return 4'd8;
            5'h0F: return 4'd9;
            5'h10: return 4'd10;
            5'h11: return 4'd11;
            default: return 4'd0;
        endcase
    endfunction

    function automatic void add(input logic [26:0] s, input logic [3:0] a,
                                input logic run, input logic mr,
                                input logic con, input logic stp);
        step_t e;
        e.s = s; e.alu = a; e.run = run; e.ill = x_ill; e.bus = x_bus;
        e.mr = mr; e.con = con; e.stop = stp; e.ir = cur_ir;
        q.push_back(e);
    endfunction

    function automatic void st(input logic [26:0] s);
        add(s, 4'd0, 1'b1, rb(), rb(), rb());
    endfunction

    function automatic void sa(input logic [26:0] s, input logic [3:0] a);
        add(s, a, 1'b1, rb(), rb(), rb());
    endfunction

    function automatic void halt_steps(input int n);
        for (int i = 0; i < n; i++) add('0, 4'd0, 1'b0, rb(), rb(), rb());
    endfunction

    // n < 0: memory never answers, so the 8-cycle timeout fires.
    function automatic void wt(input logic [26:0] s, input int n);
        if (n < 0) begin
            for (int i = 0; i < 8; i++) add(s, 4'd0, 1'b1, 1'b0, rb(), rb());
            x_bus = 1'b1;
            halt_steps(3);
        end else begin
            for (int i = 0; i < n; i++) add(s, 4'd0, 1'b1, 1'b0, rb(), rb());
            add(s, 4'd0, 1'b1, 1'b1, rb(), rb());
        end
    endfunction

    function automatic void pause(input int n);
        for (int i = 0; i < n; i++) add('0, 4'd0, 1'b0, rb(), rb(), 1'b1);
        add('0, 4'd0, 1'b0, rb(), rb(), 1'b0);
    endfunction

    function automatic void build(input logic [4:0] op, input int fw,
                                  input int ew, input logic c);
        logic [3:0] a;
        a = alu_of(op);
        cur_ir = {op, 27'($urandom)};
        st(PCOUT | MARIN | INCPC | ZIN);
        st(ZLOW | PCIN);
        wt(READ | MDRIN, fw);
        st(MDROUT | IRIN);
        st('0);
        case (op) inside
            [5'h03:5'h0D]: begin
                st(GRB | ROUT | YIN);
                sa((op > 5'h0A ? COUT : (GRC | ROUT)) | ZIN, a);
                st(ZLOW | GRA | RIN);
            end
            5'h0E, 5'h0F: begin
                st(GRB | ROUT | YIN);
                sa(GRC | ROUT | ZIN, a);
                st(ZLOW | LOIN);
                st(ZHIGH | HIIN);
            end
            5'h10, 5'h11: begin
                sa(GRB | ROUT | ZIN, a);
                st(ZLOW | GRA | RIN);
            end
            [5'h00:5'h02]: begin
                st(GRB | BAOUT | YIN);
                st(COUT | ZIN);
                if (op == 5'h01) st(ZLOW | GRA | RIN);
                else begin
                    st(ZLOW | MARIN);
                    if (op == 5'h00) begin
                        wt(READ | MDRIN, ew);
                        st(MDROUT | GRA | RIN);
                    end else begin
                        st(GRA | ROUT | MDRIN);
                        wt(WRITE, ew);
                    end
                end
            end
            5'h12: begin
                st(GRA | ROUT | CONIN);
                st(PCOUT | YIN);
                st(COUT | ZIN);
                add(ZLOW | (c ? PCIN : '0), 4'd0, 1'b1, rb(), c, rb());
            end
            5'h13: st(GRA | ROUT | PCIN);
            5'h14: begin
                st(PCOUT | GRB | RIN);
                st(GRA | ROUT | PCIN);
            end
            5'h15: st(GRA | RIN | INPOUT);
            5'h16: st(GRA | ROUT | OUTPIN);
            5'h17: st(GRA | RIN | HIOUT);
            5'h18: st(GRA | RIN | LOOUT);
            5'h19: ;
            5'h1A: halt_steps(3);
            default: begin
                x_ill = 1'b1;
                halt_steps(3);
            end
        endcase
    endfunction

    // Only the final step's Stop is seen, at the instruction boundary.
    function automatic void end_at(input int pz);
        q[q.size()-1].stop = (pz > 0);
        if (pz > 0) pause(pz);
    endfunction

    task automatic check(input step_t e, input string tag, input int n);
        logic [33:0] obs, exp;
        obs = {BusError, IllegalOp, Run, AluOp, Gra, Grb, Grc, Rin, Rout,
               BAout, Cout, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
               Yin, Zin, Zlowout, Zhighout, LOin, HIin, LOout, HIout, CONin,
               InPortout, OutPortin, Read, Write};
        exp = {e.bus, e.ill, e.run, e.alu, e.s};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s step %0d: observed %h expected %h",
                   tag, n, obs, exp);
        end
    endtask

    task automatic run_q(input string tag, input int lim);
        step_t e;
        int n = 0;
        while (q.size() > 0 && n < lim) begin
            e = q.pop_front();
            @(negedge Clock);
            IR = e.ir; MemReady = e.mr; CON_FF = e.con; Stop = e.stop;
            #1;
            check(e, tag, n);
            n++;
        end
        q.delete();
    endtask

    task automatic do_reset();
        step_t z;
        z.s = '0; z.alu = '0; z.run = 0; z.ill = 0; z.bus = 0;
        z.mr = 0; z.con = 0; z.stop = 0; z.ir = '0;
        @(negedge Clock);
        #1;
        Reset = 1'b1; Stop = 1'b0; MemReady = 1'b0;
        #2;
        check(z, "reset_async", 0);
        @(negedge Clock);
        #1;
        check(z, "reset_hold", 1);
        @(negedge Clock);
        Reset = 1'b0;
        x_ill = 1'b0;
        x_bus = 1'b0;
    endtask

    initial begin
        int pz;
        do_reset();
        build(5'h03, 0, 0, 1'b0); end_at(0); run_q("add", 1000);
        build(5'h00, 0, 3, 1'b0); end_at(0); run_q("ld_wait3", 1000);
        build(5'h02, 0, -1, 1'b0); run_q("st_timeout", 1000);
        do_reset();
        build(5'h12, 1, 0, 1'b1); end_at(0); run_q("br_taken", 1000);
        build(5'h12, 0, 0, 1'b0); end_at(0); run_q("br_not", 1000);
        build(5'h0E, 0, 0, 1'b0);
        for (int i = q.size() - 3; i < q.size(); i++) q[i].stop = 1'b1;
        pause(3);
        run_q("mul_stop", 1000);
        build(5'h19, 0, 0, 1'b0); end_at(0); run_q("nop", 1000);
        build(5'h1A, 0, 0, 1'b0); run_q("halt", 1000);
        do_reset();
        build(5'h1B, 0, 0, 1'b0); run_q("illegal", 1000);
        do_reset();
        build(5'h00, 0, 3, 1'b0); run_q("ld_cut", 9);
        do_reset();
        for (int k = 0; k < 150; k++) begin
            pz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            build(5'($urandom_range(0, 25)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), rb());
            end_at(pz);
            run_q("random", 1000);
        end
        build(5'h1F, 2, 0, 1'b0); run_q("illegal_1f", 1000);
        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised multi-cycle control sequencer for the 32-bit bus-based CPU. It fetches and decodes each instruction from `IR` and drives the single-bus datapath strobes one microstep per clock. It waits on a memory ready handshake, with an optional timeout, and supports pause, halt and illegal-opcode trapping. It sits between `IR`/`CON_FF` and the register file, ALU, `Y`/`Z`, `MAR`/`MDR`, `HI`/`LO`, `PC` and I/O ports. `AluOp` is an encoded field, not one-hot lines.

## Interface
- `MEM_TIMEOUT`, default 8: maximum cycles spent in a memory wait state before a bus error is raised; 0 disables the timeout.
- `TO_W`, default 4: width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.
- `ALUOP_W`, default 4: width of `AluOp`.
- `BR_LSB`, default 23: LSB of the 2-bit branch condition field in `IR`.
- `Clock` in 1: clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `IR` in 32: instruction register; opcode is `IR[31:27]`.
- `CON_FF` in 1: branch condition flip-flop output.
- `MemReady` in 1: memory completes the current Read/Write this cycle.
- `Stop` in 1: request to pause at the next instruction boundary.
- Datapath strobe outputs, each 1 bit: `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`, `Cout`, `PCout`, `PCin`, `IncPC`, `IRin`, `MARin`, `MDRin`, `MDRout`, `Yin`, `Zin`, `Zlowout`, `Zhighout`, `LOin`, `HIin`, `LOout`, `HIout`, `CONin`, `InPortout`, `OutPortin`, `Read`, `Write`.
- `AluOp` out `ALUOP_W`: ALU operation select.
- `Run` out 1: high while executing.
- `IllegalOp` out 1: sticky; set by an undefined opcode.
- `BusError` out 1: sticky; set by a memory timeout.

## Operation
- Outputs are Moore outputs, decoded from the registered state only. No `#` delays. Any strobe not listed for a state is 0.
- `AluOp` encoding: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHL=5, ROR=6, ROL=7, MUL=8, DIV=9, NEG=10, NOT=11. Default is 0.
- RESET: all outputs 0 and `Run`=0; next state is F0.
- Instruction-boundary check before F0: if `Stop`=1, go to PAUSE (`Run`=0) and stay there until `Stop`=0, then go to F0.
- Fetch:
  - F0: `PCout`, `MARin`, `IncPC`, `Zin`.
  - F1: `Zlowout`, `PCin`.
  - FW: `Read`, `MDRin`; hold until `MemReady`.
  - F2: `MDRout`, `IRin`.
  - DEC: no strobes; branch on `IR[31:27]`.
- Opcodes:
  - 00 ld, 01 ldi, 02 st
  - 03 add, 04 sub, 05 shr, 06 shl, 07 ror, 08 rol, 09 and, 0A or
  - 0B addi, 0C andi, 0D ori
  - 0E mul, 0F div, 10 neg, 11 not
  - 12 branch, 13 jr, 14 jal, 15 in, 16 out, 17 mfhi, 18 mflo, 19 nop, 1A halt
  - 1B–1F illegal: set `IllegalOp`, go to HALT.
- Register–register ALU (03–0A):
  - E3: `Grb`, `Rout`, `Yin`.
  - E4: `Grc`, `Rout`, `AluOp`, `Zin`.
  - E5: `Zlowout`, `Gra`, `Rin`.
- Immediate ALU (0B–0D): same as register–register, except E4 uses `Cout` in place of `Grc`/`Rout`.
- mul/div: E3 and E4 as register–register, then:
  - E5: `Zlowout`, `LOin`.
  - E6: `Zhighout`, `HIin`.
- neg/not:
  - E3: `Grb`, `Rout`, `AluOp`, `Zin`.
  - E4: `Zlowout`, `Gra`, `Rin`.
- ldi:
  - E3: `Grb`, `BAout`, `Yin`.
  - E4: `Cout`, ADD, `Zin`.
  - E5: `Zlowout`, `Gra`, `Rin`.
- ld: E3 and E4 as ldi, then:
  - E5: `Zlowout`, `MARin`.
  - EW: `Read`, `MDRin`; wait for `MemReady`.
  - E7: `MDRout`, `Gra`, `Rin`.
- st: E3–E5 as ld, then:
  - E6: `Gra`, `Rout`, `MDRin`.
  - EW: `Write`; wait for `MemReady`.
- branch (`IR[BR_LSB+1:BR_LSB]` selects the condition evaluated by the external CON logic):
  - E3: `Gra`, `Rout`, `CONin`.
  - E4: `PCout`, `Yin`.
  - E5: `Cout`, ADD, `Zin`.
  - E6: `Zlowout`, with `PCin` = `CON_FF`.
- jr: E3: `Gra`, `Rout`, `PCin`.
- jal:
  - E3: `PCout`, `Grb`, `Rin`.
  - E4: `Gra`, `Rout`, `PCin`.
- in: `Gra`, `Rin`, `InPortout`.
- out: `Gra`, `Rout`, `OutPortin`.
- mfhi: `Gra`, `Rin`, `HIout`.
- mflo: `Gra`, `Rin`, `LOout`.
- nop: go straight from DEC to the boundary check.
- halt: go to HALT.
- Every instruction's last state goes to the boundary check, never to RESET.
- HALT: `Run`=0, all strobes 0; leave only on `Reset`.

## Timing
- The wait counter clears on entering FW or EW and increments each cycle without `MemReady`.
- On `MemReady`=1, leave the wait state at the next edge. Zero-wait memory costs exactly 1 cycle in the wait state.
- Timeout, when `MEM_TIMEOUT`>0: if the counter reaches `MEM_TIMEOUT` without `MemReady`, set `BusError` and go to HALT.
- `Read`/`Write` are 0 from the HALT cycle onward.
- `MemReady` outside a wait state is ignored.
- `Stop` is sampled only at the instruction boundary; an instruction in progress always completes.
- `CON_FF` is sampled only in E6.
- Latency with zero-wait memory: F0 to the first E3 is 5 cycles.
  - Register–register ALU: 8 cycles.
  - ld and st: 10 cycles.
  - mul/div: 9 cycles.
  - nop: 5 cycles.
- `Reset` mid-instruction goes immediately to RESET. `IllegalOp`, `BusError` and the wait counter clear, and all outputs go low asynchronously.
- `IllegalOp` and `BusError` clear only on `Reset`.

## Test plan
- Reset, then `IR`=0x18800000 (add), `MemReady`=1 always. F0 is asserted 1 cycle after `Reset` falls. `Rin`+`Gra`+`Zlowout` are asserted in cycle 8. The next `PCout`+`MARin` come in cycle 9.
- ld with `MemReady` delayed 3 cycles in EW. `Read`+`MDRin` are held for 4 cycles, then E7 `MDRout`+`Rin`. `BusError` stays 0.
- st with `MemReady` tied 0 and `MEM_TIMEOUT`=8. `Write` is high for 8 cycles, then `BusError`=1, `Run`=0, and the FSM stays in HALT until `Reset`.
- Branch with `CON_FF`=1, then with `CON_FF`=0. E6 `PCin`=1 and `PCin`=0 respectively, with `Zlowout`=1 in both.
- `IR`=0xD8000000 (opcode 1B). After DEC, `IllegalOp`=1 and `Run`=0. A `Reset` pulse clears `IllegalOp` to 0.
- `Stop`=1 asserted during mul E4. E4–E6 (`LOin`, then `HIin`) still complete, then PAUSE with `Run`=0. Dropping `Stop` gives F0 on the next cycle.
